// File: rtl/rng_word_pool_if.sv
// Read-side handshake bundle for rng_word_pool: the pool is the master (valid/data),
// the CPU-side reader is the slave (ready).
interface rng_word_pool_if;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/rng_word_pool.sv
// Decimated LFSR sampler: folds the 128-bit state to 32 bits and queues words for a reader.
// Optional repetition health test is built when RNG_WORD_POOL_HEALTH_EN is defined.
module rng_word_pool #(
  parameter int DEPTH = 4,
  parameter int DECIM = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [127:0]             lfsr,
  input  logic                     enable,
  rng_word_pool_if.master          rd,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     health_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  logic [CW-1:0] cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   mem [DEPTH];

  logic          strobe;
  logic [31:0]   sample_word;
  logic          pop;
  logic          push;
  logic          full;
  logic          rep_hit;

  assign strobe      = enable && (cnt == CNT_LAST);
  assign sample_word = lfsr[31:0] ^ lfsr[63:32] ^ lfsr[95:64] ^ lfsr[127:96];

  assign rd.rd_valid = (level != '0);
  assign rd.rd_data  = rd.rd_valid ? mem[rd_ptr] : 32'h0;

  assign full = (level == LVL_FULL);
  assign pop  = rd.rd_valid && rd.rd_ready;
  // A full FIFO still accepts the word when the reader frees a slot on the same edge.
  assign push = strobe && !rep_hit && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= sample_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef RNG_WORD_POOL_HEALTH_EN
  logic [31:0] prev_word;
  logic        prev_vld;

  assign rep_hit = prev_vld && (sample_word == prev_word);

  // History tracks every strobe, including words dropped because the FIFO was full.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_word  <= '0;
      prev_vld   <= 1'b0;
      health_err <= 1'b0;
    end else if (strobe) begin
      prev_word <= sample_word;
      prev_vld  <= 1'b1;
      if (rep_hit) health_err <= 1'b1;
    end
  end
`else
  assign rep_hit    = 1'b0;
  assign health_err = 1'b0;
`endif

endmodule

// File: tb/tb_rng_word_pool.sv
// Directed bench for rng_word_pool (DECIM=4, DEPTH=4) with a word scoreboard queue.
module tb_rng_word_pool;

  logic         clk;
  logic         rst;
  logic [127:0] lfsr;
  logic         enable;
  logic [2:0]   level;
  logic         health_err;

  rng_word_pool_if rd_if ();

  rng_word_pool #(.DEPTH(4), .DECIM(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .lfsr       (lfsr),
    .enable     (enable),
    .rd         (rd_if),
    .level      (level),
    .health_err (health_err)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full sample window with k on the LFSR; the strobe lands on the 4th enabled edge.
  task automatic window(input logic [31:0] k, input bit expect_push);
    lfsr   = {96'h0, k};
    enable = 1'b1;
    repeat (4) tick();
    if (expect_push) sb.push_back(k);
  endtask

  task automatic drain(input int n);
    logic [31:0] exp;
    enable          = 1'b0;
    rd_if.rd_ready  = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      chk("drain_valid", {31'h0, rd_if.rd_valid}, 32'h1);
      chk("drain_data", rd_if.rd_data, exp);
      tick();
    end
    rd_if.rd_ready = 1'b0;
    chk("drain_empty_valid", {31'h0, rd_if.rd_valid}, 32'h0);
    chk("drain_empty_level", {29'h0, level}, 32'h0);
    chk("drain_empty_data", rd_if.rd_data, 32'h0);
    chk("drain_sb_empty", sb.size(), 32'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    enable         = 1'b0;
    lfsr           = '0;
    rd_if.rd_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    chk("rst_valid", {31'h0, rd_if.rd_valid}, 32'h0);
    chk("rst_data", rd_if.rd_data, 32'h0);
    chk("rst_level", {29'h0, level}, 32'h0);
    chk("rst_health", {31'h0, health_err}, 32'h0);

    // First-push latency
    enable = 1'b1;
    lfsr   = {96'h0, 32'h11};
    repeat (3) tick();
    chk("lat_pre_valid", {31'h0, rd_if.rd_valid}, 32'h0);
    chk("lat_pre_data", rd_if.rd_data, 32'h0);
    tick();
    sb.push_back(32'h11);
    chk("lat_valid", {31'h0, rd_if.rd_valid}, 32'h1);
    chk("lat_level", {29'h0, level}, 32'h1);
    drain(1);

    // Saturation: words 5 and 6 are dropped
    for (int k = 1; k <= 6; k++) window(k, k <= 4);
    chk("sat_level", {29'h0, level}, 32'h4);
    drain(4);

    // Full FIFO with pop on the strobe edge still accepts the new word
    for (int k = 1; k <= 4; k++) window(k, 1'b1);
    lfsr   = {96'h0, 32'h9};
    enable = 1'b1;
    repeat (3) tick();
    rd_if.rd_ready = 1'b1;
    chk("fullpop_head", rd_if.rd_data, sb.pop_front());
    sb.push_back(32'h9);
    tick();
    rd_if.rd_ready = 1'b0;
    chk("fullpop_level", {29'h0, level}, 32'h4);
    drain(4);

    // Enable gap mid-window: counter holds
    lfsr   = {96'h0, 32'h21};
    enable = 1'b1;
    repeat (2) tick();
    enable = 1'b0;
    repeat (10) tick();
    chk("gap_hold_level", {29'h0, level}, 32'h0);
    enable = 1'b1;
    tick();
    chk("gap_pre_level", {29'h0, level}, 32'h0);
    tick();
    sb.push_back(32'h21);
    chk("gap_level", {29'h0, level}, 32'h1);
    drain(1);

    // Reset mid-window discards contents and restarts decimation
    for (int k = 49; k <= 51; k++) window(k, 1'b1);
    chk("mid_level3", {29'h0, level}, 32'h3);
    enable = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_level", {29'h0, level}, 32'h0);
    chk("mid_rst_valid", {31'h0, rd_if.rd_valid}, 32'h0);
    chk("mid_rst_data", rd_if.rd_data, 32'h0);
    lfsr = {96'h0, 32'h44};
    repeat (3) tick();
    chk("mid_pre_level", {29'h0, level}, 32'h0);
    tick();
    sb.push_back(32'h44);
    chk("mid_push_level", {29'h0, level}, 32'h1);
    drain(1);
    chk("mid_health", {31'h0, health_err}, 32'h0);

    // Repeated word across three windows
`ifdef RNG_WORD_POOL_HEALTH_EN
    window(32'h5A, 1'b1);
    chk("rep_h1", {31'h0, health_err}, 32'h0);
    window(32'h5A, 1'b0);
    chk("rep_h2", {31'h0, health_err}, 32'h1);
    window(32'h5A, 1'b0);
    chk("rep_level", {29'h0, level}, 32'h1);
    chk("rep_h3", {31'h0, health_err}, 32'h1);
    drain(1);
    chk("rep_sticky", {31'h0, health_err}, 32'h1);
`else
    window(32'h5A, 1'b1);
    window(32'h5A, 1'b1);
    chk("rep_h2", {31'h0, health_err}, 32'h0);
    window(32'h5A, 1'b1);
    chk("rep_level", {29'h0, level}, 32'h3);
    chk("rep_h3", {31'h0, health_err}, 32'h0);
    drain(3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
